prirv32_idu: RTL and testbench

// Instruction decode unit of the priRV32 core. Accepts a fetched RV32I+Zicsr word with its PC, reads rs1/rs2 from the register file,
// and registers a one-hot instruction vector, immediate, operands and rd index for the execute unit.

---
 rtl/prirv32_idu.sv | 251 +++++++++++++++++++++++++
 tb/tb_prirv32_idu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prirv32_idu.sv
`default_nettype none
// ============================================================================
// prirv32_idu : RV32I+Zicsr decode stage with a valid/ready pipeline register
// Revision    : 1.0
// ============================================================================
module prirv32_idu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          ILLEGAL_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [46:0] instrset_o,
  output logic [31:0] imm_decoded_o,
  output logic [31:0] rs1_decoded_o,
  output logic [31:0] rs2_decoded_o,
  output logic [4:0]  rd_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] pc_latched_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ZERO    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [31:0] ECALL_W   = 32'h0000_0073;
  localparam logic [31:0] EBREAK_W  = 32'h0010_0073;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_zc;
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};
  assign imm_zc = {27'b0, instr_i[19:15]};

  logic [46:0] set_d;
  logic [31:0] imm_raw;
  logic        rd_en;
  logic        csr_en;

  always_comb begin
    set_d   = '0;
    imm_raw = '0;
    rd_en   = 1'b0;
    csr_en  = 1'b0;
    case (opcode)
      OPC_LUI:   begin set_d[46] = 1'b1; imm_raw = imm_u; rd_en = 1'b1; end
      OPC_AUIPC: begin set_d[45] = 1'b1; imm_raw = imm_u; rd_en = 1'b1; end
      OPC_JAL:   begin set_d[44] = 1'b1; imm_raw = imm_j; rd_en = 1'b1; end
      OPC_JALR: begin
        set_d[43] = (funct3 == 3'b000);
        imm_raw   = imm_i;
        rd_en     = 1'b1;
      end
      OPC_BRANCH: begin
        imm_raw = imm_b;
        case (funct3)
          3'b000:  set_d[42] = 1'b1;
          3'b001:  set_d[41] = 1'b1;
          3'b100:  set_d[40] = 1'b1;
          3'b101:  set_d[39] = 1'b1;
          3'b110:  set_d[38] = 1'b1;
          3'b111:  set_d[37] = 1'b1;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        imm_raw = imm_i;
        rd_en   = 1'b1;
        case (funct3)
          3'b000:  set_d[36] = 1'b1;
          3'b001:  set_d[35] = 1'b1;
          3'b010:  set_d[34] = 1'b1;
          3'b100:  set_d[33] = 1'b1;
          3'b101:  set_d[32] = 1'b1;
          default: ;
        endcase
      end
      OPC_STORE: begin
        imm_raw = imm_s;
        case (funct3)
          3'b000:  set_d[31] = 1'b1;
          3'b001:  set_d[30] = 1'b1;
          3'b010:  set_d[29] = 1'b1;
          default: ;
        endcase
      end
      OPC_OPIMM: begin
        imm_raw = imm_i;
        rd_en   = 1'b1;
        case (funct3)
          3'b000: set_d[28] = 1'b1;
          3'b010: set_d[27] = 1'b1;
          3'b011: set_d[26] = 1'b1;
          3'b100: set_d[25] = 1'b1;
          3'b110: set_d[24] = 1'b1;
          3'b111: set_d[23] = 1'b1;
          3'b001: begin
            imm_raw   = imm_sh;
            set_d[22] = (funct7 == F7_ZERO);
          end
          default: begin
            imm_raw   = imm_sh;
            set_d[21] = (funct7 == F7_ZERO);
            set_d[20] = (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        rd_en = 1'b1;
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  set_d[19] = 1'b1;
            3'b001:  set_d[17] = 1'b1;
            3'b010:  set_d[16] = 1'b1;
            3'b011:  set_d[15] = 1'b1;
            3'b100:  set_d[14] = 1'b1;
            3'b101:  set_d[13] = 1'b1;
            3'b110:  set_d[11] = 1'b1;
            default: set_d[10] = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          set_d[18] = (funct3 == 3'b000);
          set_d[12] = (funct3 == 3'b101);
        end
      end
      OPC_MISC: begin
        set_d[9] = (funct3 == 3'b000);
        set_d[8] = (funct3 == 3'b001);
      end
      OPC_SYSTEM: begin
        // ecall/ebreak are only recognised as whole words; csr ops by funct3 alone
        if (instr_i == ECALL_W) begin
          set_d[7] = 1'b1;
        end else if (instr_i == EBREAK_W) begin
          set_d[6] = 1'b1;
        end else begin
          case (funct3)
            3'b001: begin set_d[5] = 1'b1; rd_en = 1'b1; csr_en = 1'b1; end
            3'b010: begin set_d[4] = 1'b1; rd_en = 1'b1; csr_en = 1'b1; end
            3'b011: begin set_d[3] = 1'b1; rd_en = 1'b1; csr_en = 1'b1; end
            3'b101: begin set_d[2] = 1'b1; rd_en = 1'b1; csr_en = 1'b1; imm_raw = imm_zc; end
            3'b110: begin set_d[1] = 1'b1; rd_en = 1'b1; csr_en = 1'b1; imm_raw = imm_zc; end
            3'b111: begin set_d[0] = 1'b1; rd_en = 1'b1; csr_en = 1'b1; imm_raw = imm_zc; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  logic        legal;
  logic [31:0] imm_d;
  logic [4:0]  rd_d;
  logic [11:0] csr_d;
  logic        illegal_d;
  assign legal     = |set_d;
  assign imm_d     = legal ? imm_raw : 32'h0;
  assign rd_d      = (legal && rd_en) ? instr_i[11:7] : 5'd0;
  assign csr_d     = (legal && csr_en) ? instr_i[31:20] : 12'h000;
  assign illegal_d = ILLEGAL_EN && !legal;

  logic        out_valid_q;
  logic [46:0] set_q;
  logic [31:0] imm_q, rs1_q, rs2_q, pc_q;
  logic [4:0]  rd_q;
  logic [11:0] csr_q;
  logic        illegal_q;
  logic        capture;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      set_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      csr_q       <= '0;
      pc_q        <= RESET_PC;
      illegal_q   <= 1'b0;
    end else begin
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (capture) begin
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      // payload only moves on capture so a stalled instruction never re-reads the regfile
      if (capture) begin
        set_q     <= set_d;
        imm_q     <= imm_d;
        rs1_q     <= rs1_data_i;
        rs2_q     <= rs2_data_i;
        rd_q      <= rd_d;
        csr_q     <= csr_d;
        pc_q      <= pc_i;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign instrset_o    = set_q;
  assign imm_decoded_o = imm_q;
  assign rs1_decoded_o = rs1_q;
  assign rs2_decoded_o = rs2_q;
  assign rd_o          = rd_q;
  assign csr_addr_o    = csr_q;
  assign pc_latched_o  = pc_q;
  assign illegal_o     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_prirv32_idu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_prirv32_idu : randomized bench for prirv32_idu against a mask/match model
// Revision       : 1.0
// ============================================================================
module tb_prirv32_idu;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [46:0] instrset_o;
  logic [31:0] imm_decoded_o;
  logic [31:0] rs1_decoded_o;
  logic [31:0] rs2_decoded_o;
  logic [4:0]  rd_o;
  logic [11:0] csr_addr_o;
  logic [31:0] pc_latched_o;
  logic        illegal_o;

  prirv32_idu #(.RESET_PC(RST_PC), .ILLEGAL_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instrset_o(instrset_o), .imm_decoded_o(imm_decoded_o),
    .rs1_decoded_o(rs1_decoded_o), .rs2_decoded_o(rs2_decoded_o),
    .rd_o(rd_o), .csr_addr_o(csr_addr_o),
    .pc_latched_o(pc_latched_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // register file: x0 is never written, so it always reads 0
  logic [31:0] regs [32];
  always_comb begin
    rs1_data_i = regs[rs1_addr_o];
    rs2_data_i = regs[rs2_addr_o];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // mask/match pattern of instrset bit k: {mask, match}
  function automatic logic [63:0] pat(input int k);
    int bf[6]  = '{0, 1, 4, 5, 6, 7};
    int lf[5]  = '{0, 1, 2, 4, 5};
    int af[6]  = '{0, 2, 3, 4, 6, 7};
    int of3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int of7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int cf[6]  = '{1, 2, 3, 5, 6, 7};
    logic [31:0] m3 = 32'h0000_707F;
    logic [31:0] m7 = 32'hFE00_707F;
    if (k == 46) return {32'h7F, 32'h37};
    if (k == 45) return {32'h7F, 32'h17};
    if (k == 44) return {32'h7F, 32'h6F};
    if (k == 43) return {m3, 32'h67};
    if (k >= 37 && k <= 42) return {m3, 32'h63 | (32'(bf[42-k]) << 12)};
    if (k >= 32 && k <= 36) return {m3, 32'h03 | (32'(lf[36-k]) << 12)};
    if (k >= 29 && k <= 31) return {m3, 32'h23 | (32'(31-k) << 12)};
    if (k >= 23 && k <= 28) return {m3, 32'h13 | (32'(af[28-k]) << 12)};
    if (k == 22) return {m7, 32'h0000_1013};
    if (k == 21) return {m7, 32'h0000_5013};
    if (k == 20) return {m7, 32'h4000_5013};
    if (k >= 10 && k <= 19)
      return {m7, 32'h33 | (32'(of3[19-k]) << 12) | (32'(of7[19-k]) << 25)};
    if (k == 9) return {m3, 32'h0F};
    if (k == 8) return {m3, 32'h100F};
    if (k == 7) return {32'hFFFF_FFFF, 32'h0000_0073};
    if (k == 6) return {32'hFFFF_FFFF, 32'h0010_0073};
    return {m3, 32'h73 | (32'(cf[5-k]) << 12)};
  endfunction

  task automatic ref_decode(input logic [31:0] w, output logic [46:0] set,
                            output logic [31:0] imm, output logic [4:0] rd,
                            output logic [11:0] csr, output logic ill);
    int k = -1;
    int s;
    logic [63:0] p;
    set = '0;
    for (int i = 0; i < 47; i++) begin
      p = pat(i);
      if ((w & p[63:32]) == p[31:0]) begin set[i] = 1'b1; k = i; end
    end
    ill = (k < 0);
    s   = $signed(w);
    imm = 32'h0;
    if (k == 46 || k == 45) imm = w & 32'hFFFF_F000;
    else if (k == 44)
      imm = 32'((w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
    else if (k == 43 || (k >= 32 && k <= 36) || (k >= 23 && k <= 28)) imm = 32'(s >>> 20);
    else if (k >= 37 && k <= 42)
      imm = 32'((w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
    else if (k >= 29 && k <= 31) imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
    else if (k >= 20 && k <= 22) imm = 32'(w[24:20]);
    else if (k >= 0 && k <= 2) imm = 32'(w[19:15]);
    if (k < 0 || (k >= 37 && k <= 42) || (k >= 29 && k <= 31) || (k >= 6 && k <= 9)) rd = 5'd0;
    else rd = w[11:7];
    csr = (k >= 0 && k <= 5) ? w[31:20] : 12'h000;
  endtask

  // expected state of the presented instruction
  logic        m_valid;
  logic [46:0] m_set;
  logic [31:0] m_imm, m_rs1, m_rs2, m_pc;
  logic [4:0]  m_rd;
  logic [11:0] m_csr;
  logic        m_ill;

  task automatic model_reset();
    m_valid = 1'b0; m_set = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0;
    m_rd = '0; m_csr = '0; m_ill = 1'b0; m_pc = RST_PC;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready_o), 64'd1);
    chk({tag, "_set"},   64'(instrset_o), 64'd0);
    chk({tag, "_imm"},   64'(imm_decoded_o), 64'd0);
    chk({tag, "_rs1"},   64'(rs1_decoded_o), 64'd0);
    chk({tag, "_rs2"},   64'(rs2_decoded_o), 64'd0);
    chk({tag, "_rd"},    64'(rd_o), 64'd0);
    chk({tag, "_csr"},   64'(csr_addr_o), 64'd0);
    chk({tag, "_ill"},   64'(illegal_o), 64'd0);
    chk({tag, "_pc"},    64'(pc_latched_o), 64'(RST_PC));
  endtask

  // called at posedge+1; applies inputs, checks at negedge, advances model at next posedge
  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    logic        cap, n_valid;
    logic [46:0] d_set;
    logic [31:0] d_imm;
    logic [4:0]  d_rd;
    logic [11:0] d_csr;
    logic        d_ill;
    in_valid_i  = v;
    instr_i     = w;
    pc_i        = $urandom;
    out_ready_i = rdy;
    flush_i     = fl;
    if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = $urandom;
    @(negedge clk_i);
    chk("in_ready", 64'(in_ready_o), 64'(!m_valid || rdy));
    chk("rs1_addr", 64'(rs1_addr_o), 64'(w[19:15]));
    chk("rs2_addr", 64'(rs2_addr_o), 64'(w[24:20]));
    chk("out_valid", 64'(out_valid_o), 64'(m_valid));
    if (m_valid) begin
      chk("instrset", 64'(instrset_o), 64'(m_set));
      chk("imm", 64'(imm_decoded_o), 64'(m_imm));
      chk("rs1_dec", 64'(rs1_decoded_o), 64'(m_rs1));
      chk("rs2_dec", 64'(rs2_decoded_o), 64'(m_rs2));
      chk("pc", 64'(pc_latched_o), 64'(m_pc));
      chk("illegal", 64'(illegal_o), 64'(m_ill));
      if (!m_ill) begin
        chk("rd", 64'(rd_o), 64'(m_rd));
        chk("csr", 64'(csr_addr_o), 64'(m_csr));
      end
    end
    cap     = v && (!m_valid || rdy) && !fl;
    n_valid = fl ? 1'b0 : cap ? 1'b1 : (m_valid && rdy) ? 1'b0 : m_valid;
    ref_decode(w, d_set, d_imm, d_rd, d_csr, d_ill);
    @(posedge clk_i);
    #1;
    m_valid = n_valid;
    if (cap) begin
      m_set = d_set; m_imm = d_imm; m_rd = d_rd; m_csr = d_csr; m_ill = d_ill;
      m_rs1 = regs[w[19:15]]; m_rs2 = regs[w[24:20]]; m_pc = pc_i;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [63:0] p;
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 4) == 0) return r;
    p = pat(int'($urandom_range(0, 46)));
    return (r & ~p[63:32]) | p[31:0];
  endfunction

  initial begin
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    instr_i = 32'h0; pc_i = 32'h0;
    model_reset();
    #2;
    check_reset_values("reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    step(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_set", 64'(instrset_o), 64'(47'h1 << 28));
    chk("t1_imm", 64'(imm_decoded_o), 64'd5);
    chk("t1_rd", 64'(rd_o), 64'd1);

    step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
    chk("t2_set", 64'(instrset_o), 64'(47'h1 << 42));
    chk("t2_imm", 64'(imm_decoded_o), 64'hFFFF_FFFC);
    chk("t2_rd", 64'(rd_o), 64'd0);
    chk("t2_rs1", 64'(rs1_decoded_o), 64'd0);
    chk("t2_rs2", 64'(rs2_decoded_o), 64'd0);

    step(1'b1, 32'h1234_52B7, 1'b1, 1'b0);
    chk("t3_set", 64'(instrset_o), 64'(47'h1 << 46));
    chk("t3_imm", 64'(imm_decoded_o), 64'h1234_5000);
    chk("t3_rd", 64'(rd_o), 64'd5);
    step(1'b1, 32'h4020_8033, 1'b1, 1'b0);
    chk("t3_sub", 64'(instrset_o), 64'(47'h1 << 18));

    step(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    chk("t4_ill", 64'(illegal_o), 64'd1);
    chk("t4_set", 64'(instrset_o), 64'd0);
    chk("t4_valid", 64'(out_valid_o), 64'd1);
    step(1'b1, 32'h0220_8033, 1'b1, 1'b0);
    chk("t4_f7", 64'(illegal_o), 64'd1);

    step(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0010_8133, 1'b0, 1'b0);
      chk("t5_hold_ready", 64'(in_ready_o), 64'd0);
      chk("t5_hold_set", 64'(instrset_o), 64'(47'h1 << 28));
    end
    step(1'b1, 32'h0010_8133, 1'b1, 1'b0);
    chk("t5_drain1", 64'(instrset_o), 64'(47'h1 << 19));
    step(1'b1, 32'h4000_0033, 1'b1, 1'b0);
    chk("t5_drain2", 64'(instrset_o), 64'(47'h1 << 18));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    step(1'b1, 32'h0010_8133, 1'b1, 1'b1);
    chk("t6_flush", 64'(out_valid_o), 64'd0);
    step(1'b1, 32'h3000_2073, 1'b0, 1'b0);
    step(1'b1, 32'h0010_8133, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
